// File: rtl/memory_pkg.sv
// memory_pkg
// Shared definitions for the routing memory block: default sizes for the
// word buffer and output window, and the routing FSM state encoding.
package memory_pkg;

    localparam int MAX_WIDTH_DEF  = 9;    // byte lanes in the routed window
    localparam int DEPTH_DEF      = 128;  // buffer word count
    localparam int DATA_WIDTH_DEF = 8;    // bits per word

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/memory_buffer.sv
// memory_buffer
// Word storage with one write port and one synchronous read port.
// A read issued on an edge presents its word after that edge; a read and a
// write to the same address on the same edge return the previous contents.
// Ports:
//   clk      - rising-edge clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - read strobe
//   rd_addr  - read address
//   rd_data  - registered read data (valid the cycle after rd_en)
module memory_buffer
    import memory_pkg::*;
#(
    parameter int Depth     = DEPTH_DEF,
    parameter int DataWidth = DATA_WIDTH_DEF,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [DataWidth-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [AddrWidth-1:0] rd_addr,
    output logic [DataWidth-1:0] rd_data
);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rd_data_q;

    // Contents are never reset; both ports use non-blocking updates so a
    // colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/memory_top.sv
// memory_top
// Buffers written words and, on request, routes a contiguous (wrapping)
// address range out through a shift window: each read word enters lane 0 and
// older words move up, the oldest falling off beyond MaxWidth lanes.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset (buffer contents kept)
//   writeEn    - buffer write strobe, honoured in every state
//   writeAddr  - buffer write address
//   dataIn     - buffer write data
//   routeEn    - level request that starts a pass and holds its result
//   startAddr  - first address of the pass (inclusive)
//   finalAddr  - end address of the pass (exclusive)
//   finished   - high once the last word has landed in dataOut
//   dataOut    - routed word window, newest word in lane 0
module memory_top
    import memory_pkg::*;
#(
    parameter int MaxWidth  = MAX_WIDTH_DEF,
    parameter int Depth     = DEPTH_DEF,
    parameter int DataWidth = DATA_WIDTH_DEF,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          writeEn,
    input  logic [AddrWidth-1:0]          writeAddr,
    input  logic [DataWidth-1:0]          dataIn,
    input  logic                          routeEn,
    input  logic [AddrWidth-1:0]          startAddr,
    input  logic [AddrWidth-1:0]          finalAddr,
    output logic                          finished,
    output logic [MaxWidth*DataWidth-1:0] dataOut
);

    localparam int OutWidth = MaxWidth * DataWidth;

    state_t                 state_q, state_d;
    logic [AddrWidth-1:0]   rd_addr_q, rd_addr_d;
    logic [AddrWidth-1:0]   end_addr_q, end_addr_d;
    logic [AddrWidth-1:0]   next_addr;
    logic                   rd_vld_q, rd_vld_d;
    logic                   finished_q, finished_d;
    logic [OutWidth-1:0]    data_out_q, data_out_d;
    logic                   rd_en;
    logic [DataWidth-1:0]   rd_data;

    memory_buffer #(
        .Depth     (Depth),
        .DataWidth (DataWidth),
        .AddrWidth (AddrWidth)
    ) buffer (
        .clk     (clk),
        .wr_en   (writeEn),
        .wr_addr (writeAddr),
        .wr_data (dataIn),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_q),
        .rd_data (rd_data)
    );

    always_comb begin
        // Explicit wrap so non-power-of-two depths also cycle back to 0.
        next_addr  = (rd_addr_q == AddrWidth'(Depth - 1)) ? '0 : rd_addr_q + 1'b1;
        rd_en      = (state_q == READ);

        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        end_addr_d = end_addr_q;
        finished_d = finished_q;
        data_out_d = data_out_q;
        // A read issued last cycle lands now, one word per cycle.
        rd_vld_d   = rd_en;

        if (rd_vld_q) begin
            data_out_d = {data_out_q[OutWidth-DataWidth-1:0], rd_data};
        end

        unique case (state_q)
            IDLE: begin
                if (routeEn) begin
                    rd_addr_d  = startAddr;
                    end_addr_d = finalAddr;
                    data_out_d = '0;
                    state_d    = (startAddr == finalAddr) ? DONE : READ;
                end
            end
            READ: begin
                // routeEn is ignored here: a started pass always completes.
                rd_addr_d = next_addr;
                if (next_addr == end_addr_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // First DONE cycle coincides with the final word landing, so
                // finished is raised unconditionally before honouring routeEn.
                if (!finished_q) begin
                    finished_d = 1'b1;
                end else if (!routeEn) begin
                    finished_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            end_addr_q <= '0;
            rd_vld_q   <= 1'b0;
            finished_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            end_addr_q <= end_addr_d;
            rd_vld_q   <= rd_vld_d;
            finished_q <= finished_d;
            data_out_q <= data_out_d;
        end
    end

    assign finished = finished_q;
    assign dataOut  = data_out_q;

endmodule

// File: tb/tb_memory_top.sv
// tb_memory_top
// Bench for memory_top: directed and randomized routing passes compared
// against a behavioural model of the buffer contents and the routed window.
module tb_memory_top;

    localparam int MW    = 9;
    localparam int DEPTH = 128;
    localparam int DW    = 8;
    localparam int AW    = 7;
    localparam int OW    = MW * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          writeEn;
    logic [AW-1:0] writeAddr;
    logic [DW-1:0] dataIn;
    logic          routeEn;
    logic [AW-1:0] startAddr;
    logic [AW-1:0] finalAddr;
    logic          finished;
    logic [OW-1:0] dataOut;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_mem [DEPTH];

    memory_top #(
        .MaxWidth  (MW),
        .Depth     (DEPTH),
        .DataWidth (DW),
        .AddrWidth (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .writeEn   (writeEn),
        .writeAddr (writeAddr),
        .dataIn    (dataIn),
        .routeEn   (routeEn),
        .startAddr (startAddr),
        .finalAddr (finalAddr),
        .finished  (finished),
        .dataOut   (dataOut)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a, input logic [DW-1:0] d);
        writeEn   = 1'b1;
        writeAddr = AW'(a);
        dataIn    = d;
        tick();
        writeEn   = 1'b0;
        model_mem[a] = d;
    endtask

    function automatic int model_len(input int s, input int f);
        return (f - s + DEPTH) % DEPTH;
    endfunction

    // Window after a pass: every word of the range in order, shifted in from
    // the low end, keeping only the last MW words.
    function automatic logic [OW-1:0] model_window(input int s, input int f);
        logic [OW-1:0] w;
        w = '0;
        for (int i = 0; i < model_len(s, f); i++) begin
            w = (w << DW) | OW'(model_mem[(s + i) % DEPTH]);
        end
        return w;
    endfunction

    // Start a pass; returns the number of edges after the start edge until
    // finished is seen (-1 on timeout) and the window at that point.
    task automatic run_pass(input int s, input int f, input bit drop_early,
                            output int edges, output logic [OW-1:0] dout);
        routeEn   = 1'b1;
        startAddr = AW'(s);
        finalAddr = AW'(f);
        tick();
        startAddr = AW'($urandom);
        finalAddr = AW'($urandom);
        if (drop_early) routeEn = 1'b0;
        edges = 0;
        while (finished !== 1'b1 && edges < 400) begin
            tick();
            edges++;
        end
        if (finished !== 1'b1) edges = -1;
        dout = dataOut;
    endtask

    task automatic release_route();
        routeEn = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (finished !== 1'b0) begin
            bad++;
            $display("FAIL reset_finished: got %b want 0", finished);
        end
        total++;
        if (dataOut !== '0) begin
            bad++;
            $display("FAIL reset_dataout: got %h want 0", dataOut);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_range();
        int edges;
        logic [OW-1:0] dout;
        for (int i = 0; i <= 80; i++) write_word(i, DW'(i));
        run_pass(0, 81, 1'b0, edges, dout);
        total++;
        if (edges !== 82) begin
            bad++;
            $display("FAIL full_latency: got %0d edges want 82", edges);
        end
        total++;
        if (dout !== 72'h48494a4b4c4d4e4f50) begin
            bad++;
            $display("FAIL full_window: got %h want 48494a4b4c4d4e4f50", dout);
        end
        release_route();
    endtask

    task automatic test_three_words();
        int edges;
        logic [OW-1:0] dout;
        write_word(5, 8'h11);
        write_word(6, 8'h22);
        write_word(7, 8'h33);
        run_pass(5, 8, 1'b0, edges, dout);
        total++;
        if (edges !== 4) begin
            bad++;
            $display("FAIL three_latency: got %0d edges want 4", edges);
        end
        total++;
        if (dout !== 72'h112233) begin
            bad++;
            $display("FAIL three_window: got %h want 112233", dout);
        end
        release_route();
    endtask

    task automatic test_empty();
        int edges;
        logic [OW-1:0] dout;
        run_pass(10, 10, 1'b0, edges, dout);
        total++;
        if (edges !== 1) begin
            bad++;
            $display("FAIL empty_latency: got %0d edges want 1", edges);
        end
        total++;
        if (dout !== '0) begin
            bad++;
            $display("FAIL empty_window: got %h want 0", dout);
        end
        release_route();
    endtask

    task automatic test_wrap();
        int edges;
        logic [OW-1:0] dout;
        write_word(126, 8'hA1);
        write_word(127, 8'hA2);
        write_word(0,   8'hA3);
        write_word(1,   8'hA4);
        run_pass(126, 2, 1'b0, edges, dout);
        total++;
        if (edges !== 5) begin
            bad++;
            $display("FAIL wrap_latency: got %0d edges want 5", edges);
        end
        total++;
        if (dout !== 72'hA1A2A3A4) begin
            bad++;
            $display("FAIL wrap_window: got %h want a1a2a3a4", dout);
        end
        release_route();
    endtask

    task automatic test_done_hold_and_drop();
        int edges;
        logic [OW-1:0] dout;
        run_pass(20, 25, 1'b0, edges, dout);
        total++;
        if (dout !== model_window(20, 25)) begin
            bad++;
            $display("FAIL hold_window: got %h want %h", dout, model_window(20, 25));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (finished !== 1'b1 || dataOut !== dout) begin
                bad++;
                $display("FAIL hold_done: got finished=%b data=%h want 1 %h", finished, dataOut, dout);
            end
        end
        routeEn = 1'b0;
        tick();
        total++;
        if (finished !== 1'b0) begin
            bad++;
            $display("FAIL drop_finished: got %b want 0", finished);
        end
        total++;
        if (dataOut !== dout) begin
            bad++;
            $display("FAIL drop_window: got %h want %h", dataOut, dout);
        end
        tick();
        total++;
        if (finished !== 1'b0 || dataOut !== dout) begin
            bad++;
            $display("FAIL idle_hold: got finished=%b data=%h want 0 %h", finished, dataOut, dout);
        end
    endtask

    task automatic test_reset_mid_read();
        int edges;
        int seen;
        logic [OW-1:0] dout;
        routeEn   = 1'b1;
        startAddr = AW'(0);
        finalAddr = AW'(81);
        tick();
        for (int i = 0; i < 5; i++) tick();
        rst     = 1'b1;
        routeEn = 1'b0;
        tick();
        rst = 1'b0;
        total++;
        if (finished !== 1'b0 || dataOut !== '0) begin
            bad++;
            $display("FAIL midreset_state: got finished=%b data=%h want 0 0", finished, dataOut);
        end
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (finished !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midreset_pulse: got %0d finished cycles want 0", seen);
        end
        run_pass(0, 81, 1'b0, edges, dout);
        total++;
        if (edges !== 82 || dout !== model_window(0, 81)) begin
            bad++;
            $display("FAIL midreset_next: got %0d edges %h want 82 %h", edges, dout, model_window(0, 81));
        end
        release_route();
    endtask

    task automatic test_drop_in_read();
        int edges;
        logic [OW-1:0] dout;
        run_pass(30, 40, 1'b1, edges, dout);
        total++;
        if (edges !== 11 || dout !== model_window(30, 40)) begin
            bad++;
            $display("FAIL early_drop: got %0d edges %h want 11 %h", edges, dout, model_window(30, 40));
        end
        tick();
        total++;
        if (finished !== 1'b0) begin
            bad++;
            $display("FAIL early_drop_clear: got %b want 0", finished);
        end
    endtask

    task automatic test_random();
        int edges;
        int s;
        int n;
        int f;
        bit drop;
        logic [OW-1:0] dout;
        for (int a = 0; a < DEPTH; a++) write_word(a, DW'($urandom));
        for (int k = 0; k < 12; k++) begin
            s    = int'($urandom_range(DEPTH - 1, 0));
            n    = int'($urandom_range(20, 0));
            f    = (s + n) % DEPTH;
            drop = 1'($urandom_range(1, 0));
            run_pass(s, f, drop, edges, dout);
            total++;
            if (edges !== n + 1 || dout !== model_window(s, f)) begin
                bad++;
                $display("FAIL random_pass%0d: s=%0d f=%0d got %0d edges %h want %0d %h",
                         k, s, f, edges, dout, n + 1, model_window(s, f));
            end
            release_route();
        end
    endtask

    initial begin
        rst       = 1'b1;
        writeEn   = 1'b0;
        writeAddr = '0;
        dataIn    = '0;
        routeEn   = 1'b0;
        startAddr = '0;
        finalAddr = '0;
        test_reset();
        test_full_range();
        test_three_words();
        test_empty();
        test_wrap();
        test_done_hold_and_drop();
        test_reset_mid_read();
        test_drop_in_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_top.md
MEMORY_TOP -- requirements
Module: memory_top

Interface
REQ-001 SHALL have parameter MaxWidth, default 9, number of byte lanes in dataOut.
REQ-002 SHALL have parameter Depth, default 128, buffer word count.
REQ-003 SHALL have parameter DataWidth, default 8, bits per word.
REQ-004 SHALL have parameter AddrWidth, default $clog2(Depth), address width.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-007 SHALL have port writeEn, input, 1 bit, buffer write strobe.
REQ-008 SHALL have port writeAddr, input, AddrWidth bits, write address.
REQ-009 SHALL have port dataIn, input, DataWidth bits, write data.
REQ-010 SHALL have port routeEn, input, 1 bit, level request to start and hold a routing pass.
REQ-011 SHALL have port startAddr, input, AddrWidth bits, first address read (inclusive).
REQ-012 SHALL have port finalAddr, input, AddrWidth bits, end address (exclusive).
REQ-013 SHALL have port finished, output, 1 bit, pass complete.
REQ-014 SHALL have port dataOut, output, MaxWidth*DataWidth bits, routed word window.

Function
REQ-015 SHALL write dataIn to buffer[writeAddr] on each edge with writeEn=1, in every state.
REQ-016 SHALL perform synchronous buffer reads with 1-cycle latency; same-address read and write in one cycle SHALL return the old data.
REQ-017 SHALL implement FSM states IDLE, READ, DONE.
REQ-018 In IDLE with routeEn=1: SHALL latch startAddr and finalAddr into rdAddr and endAddr, clear dataOut, and go to READ; if startAddr==finalAddr it SHALL go directly to DONE.
REQ-019 In READ: SHALL issue a read of rdAddr each cycle and increment rdAddr modulo Depth; after issuing the read where rdAddr+1==endAddr, SHALL go to DONE.
REQ-020 Each returned word SHALL be shifted in: dataOut <= {dataOut[(MaxWidth-1)*DataWidth-1:0], word}, so the newest word is in lane 0 and the oldest is discarded beyond MaxWidth words.
REQ-021 finished SHALL rise on the same edge that loads the final word, i.e. N+1 edges after the edge sampling routeEn, for a range of N words.
REQ-022 For an empty range, finished SHALL rise on the edge after the edge sampling routeEn, with dataOut all zero.
REQ-023 Ranges with finalAddr < startAddr SHALL wrap past Depth-1 to 0.
REQ-024 In DONE: SHALL hold finished=1 and dataOut while routeEn=1; on routeEn=0 SHALL return to IDLE, clearing finished while holding dataOut.
REQ-025 Deasserting routeEn during READ SHALL NOT abort the pass.
REQ-026 startAddr and finalAddr changes after the start edge SHALL NOT affect the pass.

Reset
REQ-027 On rst=1 at an edge: state SHALL become IDLE, finished 0, dataOut 0, and rdAddr and endAddr 0.
REQ-028 rst SHALL take priority over routeEn and writeEn; buffer contents SHALL NOT be cleared.
REQ-029 Reset during READ SHALL abandon the pass; no finished pulse SHALL follow.

Structure
REQ-030 The defaults for MaxWidth, Depth, DataWidth and the FSM state encoding SHALL live in a shared package.
REQ-031 The storage SHALL be one sub-module, buffer: single write port, single synchronous read port.
REQ-032 The FSM, address counter and shift window SHALL reside in memory_top.

Verification
REQ-033 The bench SHALL write words 0x00..0x50 at addresses 0..80, then route start=0, final=81; dataOut SHALL be 0x48494a4b4c4d4e4f50 and finished SHALL rise 82 edges after the start edge.
REQ-034 The bench SHALL route a range of 3 words (0x11, 0x22, 0x33 at addresses 5..7); dataOut SHALL be 0x112233 in the low 3 lanes with the upper lanes zero.
REQ-035 The bench SHALL route start=final=10; finished SHALL rise 1 edge after the start edge with dataOut=0.
REQ-036 The bench SHALL route a wrap range with start=126, final=2 (4 words); the words SHALL arrive in order 126, 127, 0, 1.
REQ-037 The bench SHALL assert rst mid-READ; finished SHALL remain 0 and dataOut SHALL be 0; a following pass SHALL complete normally.
REQ-038 The bench SHALL drop routeEn in DONE; finished SHALL fall on the next edge with dataOut unchanged.
